// File: rtl/vga_sync_gen.sv
// 640x480 VGA timing generator: pixel-tick divider, horizontal/vertical scan counters, registered sync decode.
// Define VGA_SYNC_FRAME_CNT_EN to add the 8-bit frame_count output used for blink/animation.
module vga_sync_gen #(
    parameter int CLK_DIV   = 4,
    parameter int H_DISPLAY = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        p_tick,
    output logic [10:0] pixel_x,
    output logic [10:0] pixel_y,
    output logic        video_on,
    output logic        hsync,
    output logic        vsync,
    output logic        frame_start
`ifdef VGA_SYNC_FRAME_CNT_EN
    ,
    output logic [7:0]  frame_count
`endif
);
    localparam int H_TOTAL = H_DISPLAY + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_DISPLAY + V_FP + V_SYNC + V_BP;

    localparam logic [4:0]  DIV_LAST = 5'(CLK_DIV - 1);
    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS    = 11'(H_DISPLAY);
    localparam logic [10:0] V_VIS    = 11'(V_DISPLAY);
    localparam logic [10:0] HS_FIRST = 11'(H_DISPLAY + H_FP);
    localparam logic [10:0] HS_LAST  = 11'(H_DISPLAY + H_FP + H_SYNC - 1);
    localparam logic [10:0] VS_FIRST = 11'(V_DISPLAY + V_FP);
    localparam logic [10:0] VS_LAST  = 11'(V_DISPLAY + V_FP + V_SYNC - 1);

    logic [4:0]  div_q, div_d;
    logic [10:0] x_q, x_d;
    logic [10:0] y_q, y_d;
    logic        vid_q, vid_d;
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;
    logic        fs_q, fs_d;
    logic        tick;

    function automatic logic in_range(input logic [10:0] v,
                                      input logic [10:0] lo,
                                      input logic [10:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

    assign tick = (div_q == DIV_LAST);

    // Decodes use the next-state position so they land on the same edge as the counters.
    always_comb begin
        div_d = tick ? 5'd0 : div_q + 5'd1;
        x_d   = x_q;
        y_d   = y_q;
        vid_d = vid_q;
        hs_d  = hs_q;
        vs_d  = vs_q;
        fs_d  = 1'b0;
        if (tick) begin
            if (x_q == H_LAST) begin
                x_d = 11'd0;
                y_d = (y_q == V_LAST) ? 11'd0 : y_q + 11'd1;
            end else begin
                x_d = x_q + 11'd1;
            end
            vid_d = (x_d < H_VIS) && (y_d < V_VIS);
            hs_d  = !in_range(x_d, HS_FIRST, HS_LAST);
            vs_d  = !in_range(y_d, VS_FIRST, VS_LAST);
            fs_d  = (x_d == 11'd0) && (y_d == 11'd0);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q <= 5'd0;
            x_q   <= 11'd0;
            y_q   <= 11'd0;
            vid_q <= 1'b0;
            hs_q  <= 1'b1;
            vs_q  <= 1'b1;
            fs_q  <= 1'b0;
        end else begin
            div_q <= div_d;
            x_q   <= x_d;
            y_q   <= y_d;
            vid_q <= vid_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
            fs_q  <= fs_d;
        end
    end

`ifdef VGA_SYNC_FRAME_CNT_EN
    logic [7:0] fc_q, fc_d;

    assign fc_d = fs_d ? fc_q + 8'd1 : fc_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fc_q <= 8'd0;
        end else begin
            fc_q <= fc_d;
        end
    end

    assign frame_count = fc_q;
`endif

    assign p_tick      = tick;
    assign pixel_x     = x_q;
    assign pixel_y     = y_q;
    assign video_on    = vid_q;
    assign hsync       = hs_q;
    assign vsync       = vs_q;
    assign frame_start = fs_q;

endmodule
